// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data memory arbiter.
//   arb_state_t : transaction FSM encoding (IDLE -> ACCESS -> RESP -> IDLE)
//   PORT_CPU    : requester index of the CPU load/store port
//   PORT_DMA    : requester index of the DMA/loader port
package data_memory_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/data_memory_arbiter_rr_arb2.sv
// Two-way round-robin pick, purely combinational.
//   req0, req1  : pending requests of port 0 / port 1
//   last_owner  : port that completed the most recent transaction
//   grant_valid : at least one request is pending
//   grant_idx   : winning port; on contention the port that was not served last
module rr_arb2
    import data_memory_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_idx
);

    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant_idx = ~last_owner;
        end else if (req1) begin
            grant_idx = PORT_DMA;
        end else begin
            grant_idx = PORT_CPU;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares a single-port data memory between the CPU (port 0) and the DMA/loader
// (port 1). One access per 3-cycle transaction, round-robin on contention.
// Every output is registered.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   req*/we*/addr*/wdata* : requester side; fields are sampled at grant
//   gnt*                  : one-cycle pulse, request accepted
//   done*                 : one-cycle pulse, access complete (rdata* valid for reads)
//   rdata*                : per-port read data, held until that port's next read
//   mem_we/mem_re/mem_addr/mem_wdata : memory strobes and bus, driven only here
//   mem_rdata             : combinational read data from the memory
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no transaction; arbitrate and latch the winner's request
// ST_ACCESS | memory strobe active for exactly one cycle, gnt pulse visible
// ST_RESP   | strobes off, done pulse visible, read data already captured
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state, state_nxt;
    logic              owner, owner_nxt;
    logic              last_owner, last_owner_nxt;
    logic              cur_we, cur_we_nxt;
    logic              gnt0_nxt, gnt1_nxt;
    logic              done0_nxt, done1_nxt;
    logic              mem_we_nxt, mem_re_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic [DATA_W-1:0] rdata0_nxt, rdata1_nxt;

    logic              grant_valid, grant_idx;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 u_arb (
        .req0        (req0),
        .req1        (req1),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign sel_we    = (grant_idx == PORT_DMA) ? we1    : we0;
    assign sel_addr  = (grant_idx == PORT_DMA) ? addr1  : addr0;
    assign sel_wdata = (grant_idx == PORT_DMA) ? wdata1 : wdata0;

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        cur_we_nxt     = cur_we;
        gnt0_nxt       = 1'b0;
        gnt1_nxt       = 1'b0;
        done0_nxt      = 1'b0;
        done1_nxt      = 1'b0;
        mem_we_nxt     = 1'b0;
        mem_re_nxt     = 1'b0;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        rdata0_nxt     = rdata0;
        rdata1_nxt     = rdata1;

        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    owner_nxt     = grant_idx;
                    cur_we_nxt    = sel_we;
                    mem_addr_nxt  = sel_addr;
                    mem_wdata_nxt = sel_wdata;
                    // strobes are registered so they line up with ST_ACCESS
                    mem_we_nxt    = sel_we;
                    mem_re_nxt    = ~sel_we;
                    gnt0_nxt      = (grant_idx == PORT_CPU);
                    gnt1_nxt      = (grant_idx == PORT_DMA);
                    state_nxt     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // memory read data is combinational on mem_addr, capture it now
                if (owner == PORT_CPU) begin
                    done0_nxt = 1'b1;
                    if (!cur_we) begin
                        rdata0_nxt = mem_rdata;
                    end
                end else begin
                    done1_nxt = 1'b1;
                    if (!cur_we) begin
                        rdata1_nxt = mem_rdata;
                    end
                end
                last_owner_nxt = owner;
                state_nxt      = ST_RESP;
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            owner      <= PORT_CPU;
            last_owner <= PORT_DMA;
            cur_we     <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            cur_we     <= cur_we_nxt;
            gnt0       <= gnt0_nxt;
            gnt1       <= gnt1_nxt;
            done0      <= done0_nxt;
            done1      <= done1_nxt;
            mem_we     <= mem_we_nxt;
            mem_re     <= mem_re_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            rdata0     <= rdata0_nxt;
            rdata1     <= rdata1_nxt;
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed scenarios followed by randomized
// two-port traffic. A reference model decides which port is served and what
// each access returns; a monitor compares grants, strobes and responses.
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we = 2'b00;
    logic [7:0]  addr [2];
    logic [7:0]  wdata [2];
    logic        gnt0, gnt1, done0, done1;
    logic [7:0]  rdata0, rdata1;
    logic        mem_we, mem_re;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  sim_mem [256];
    logic [7:0]  ref_mem [256];
    wire  [1:0]  gnt  = {gnt1, gnt0};
    wire  [1:0]  done = {done1, done0};

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural single-port memory with combinational read
    assign mem_rdata = sim_mem[mem_addr];
    always @(posedge clk) if (mem_we) sim_mem[mem_addr] <= mem_wdata;

    data_memory_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req[0]),
        .req1      (req[1]),
        .we0       (we[0]),
        .we1       (we[1]),
        .addr0     (addr[0]),
        .addr1     (addr[1]),
        .wdata0    (wdata[0]),
        .wdata1    (wdata[1]),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int         port;
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp_rd;
        int         stamp;
    } txn_t;

    txn_t       exp_q[$];
    int         gnt_log[$];
    logic [7:0] rd_model [2];

    // Reference model: a transaction occupies three cycles; whenever the
    // arbiter is free, a lone requester wins, and under contention the port
    // that was not served last wins. Memory effects are applied in grant order.
    initial begin
        int   busy;
        int   last_served;
        int   win;
        txn_t t;
        busy = 0;
        last_served = 1;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy = 0;
                last_served = 1;
            end else if (busy > 0) begin
                busy--;
            end else if (req != 2'b00) begin
                if (req == 2'b11) win = 1 - last_served;
                else              win = req[1] ? 1 : 0;
                t.port   = win;
                t.w      = we[win];
                t.a      = addr[win];
                t.d      = wdata[win];
                t.exp_rd = ref_mem[t.a];
                t.stamp  = cyc;
                if (t.w) ref_mem[t.a] = t.d;
                last_served = win;
                busy = 2;
                exp_q.push_back(t);
            end
        end
    end

    // Monitor: compares what the DUT presents against the expected queue.
    initial begin
        txn_t t;
        rd_model[0] = 8'h00;
        rd_model[1] = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                rd_model[0] = 8'h00;
                rd_model[1] = 8'h00;
            end else begin
                check("strobe_exclusive", {31'd0, mem_we & mem_re}, 32'd0);
                if (gnt != 2'b00) begin
                    gnt_log.push_back(gnt1 ? 1 : 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_gnt", {30'd0, gnt}, 32'd0);
                    end else begin
                        t = exp_q[0];
                        check("gnt_port", {30'd0, gnt}, 32'd1 << t.port);
                        check("gnt_cycle", cyc, t.stamp + 1);
                        check("mem_we", {31'd0, mem_we}, {31'd0, t.w});
                        check("mem_re", {31'd0, mem_re}, {31'd0, ~t.w});
                        check("mem_addr", {24'd0, mem_addr}, {24'd0, t.a});
                        check("mem_wdata", {24'd0, mem_wdata}, {24'd0, t.d});
                    end
                end else begin
                    check("idle_strobes", {30'd0, mem_we, mem_re}, 32'd0);
                    if (exp_q.size() > 0 && cyc == exp_q[0].stamp + 1)
                        check("gnt_missing", {30'd0, gnt}, 32'd1 << exp_q[0].port);
                end
                if (done != 2'b00) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", {30'd0, done}, 32'd0);
                    end else begin
                        t = exp_q.pop_front();
                        check("done_port", {30'd0, done}, 32'd1 << t.port);
                        check("done_cycle", cyc, t.stamp + 2);
                        if (!t.w) rd_model[t.port] = t.exp_rd;
                        check("rdata0", {24'd0, rdata0}, {24'd0, rd_model[0]});
                        check("rdata1", {24'd0, rdata1}, {24'd0, rd_model[1]});
                    end
                end else if (exp_q.size() > 0 && cyc >= exp_q[0].stamp + 2) begin
                    check("done_missing", {30'd0, done}, 32'd1 << exp_q[0].port);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Waits for grant then done of port p. Entered and left at posedge+1.
    task automatic finish_req(input int p, input bit drop, input bit keep, output int done_cyc);
        bit got;
        done_cyc = -1;
        got = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (gnt[p]) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            check("gnt_timeout", {30'd0, gnt}, 32'd1 << p);
            @(posedge clk);
            #1 req[p] = 1'b0;
            return;
        end
        if (drop) begin
            @(posedge clk);
            #1 req[p] = 1'b0;
        end
        got = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done[p]) begin
                got = 1;
                break;
            end
        end
        if (!got) check("done_timeout", {30'd0, done}, 32'd1 << p);
        else      done_cyc = cyc;
        @(posedge clk);
        #1;
        if (!keep) req[p] = 1'b0;
    endtask

    // mode 0: hold req until done; 1: drop req after grant; 2: drop req after one decision edge
    task automatic do_req(input int p, input logic w, input logic [7:0] a, input logic [7:0] d,
                          input int mode, input bit keep, output int done_cyc);
        we[p]    = w;
        addr[p]  = a;
        wdata[p] = d;
        req[p]   = 1'b1;
        if (mode == 2) begin
            @(negedge clk);
            @(posedge clk);
            #1 req[p] = 1'b0;
            @(negedge clk);
            if (!gnt[p]) begin
                done_cyc = -1;
                @(posedge clk);
                #1;
                return;
            end
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (done[p]) break;
            end
            done_cyc = cyc;
            @(posedge clk);
            #1;
        end else begin
            finish_req(p, mode == 1, keep, done_cyc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, dc0, dc1;
        for (int i = 0; i < 256; i++) begin
            sim_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        addr[0] = 8'h00; addr[1] = 8'h00;
        wdata[0] = 8'h00; wdata[1] = 8'h00;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_gnt", {30'd0, gnt}, 32'd0);
        check("rst_done", {30'd0, done}, 32'd0);
        check("rst_strobes", {30'd0, mem_we, mem_re}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_rdata0", {24'd0, rdata0}, 32'd0);
        check("rst_rdata1", {24'd0, rdata1}, 32'd0);
        @(posedge clk);
        #1;

        // port 0 write then read back
        do_req(0, 1'b1, 8'h10, 8'hA5, 0, 0, dc);
        do_req(0, 1'b0, 8'h10, 8'h00, 0, 0, dc);
        check("t1_rdata0", {24'd0, rdata0}, 32'hA5);

        // both ports requesting straight out of reset
        reset = 1'b1;
        fork
            do_req(0, 1'b0, 8'h10, 8'h00, 0, 0, dc0);
            do_req(1, 1'b0, 8'h30, 8'h00, 0, 0, dc1);
            begin
                repeat (2) @(posedge clk);
                #1 reset = 1'b0;
            end
        join
        check("t2_done0_first", {31'd0, dc0 < dc1}, 32'd1);
        check("t2_done1_gap", dc1, dc0 + 3);
        check("t2_rdata0", {24'd0, rdata0}, 32'hA5);

        // six back-to-back transactions under permanent contention
        gnt_log.delete();
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    int d0;
                    do_req(0, 1'b1, 8'h40 + 8'(i), 8'($urandom), 0, i < 2, d0);
                end
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    int d1;
                    do_req(1, 1'b1, 8'h50 + 8'(i), 8'($urandom), 0, i < 2, d1);
                end
            end
        join
        check("t3_grant_count", gnt_log.size(), 32'd6);
        if (gnt_log.size() > 0) check("t3_first_grant", gnt_log[0], 32'd0);
        for (int i = 1; i < gnt_log.size(); i++)
            check("t3_alternate", gnt_log[i], 1 - gnt_log[i-1]);

        // top address from the DMA port, read back by the CPU port
        do_req(1, 1'b1, 8'h31, 8'h5A, 0, 0, dc);
        do_req(1, 1'b0, 8'h31, 8'h00, 0, 0, dc);
        do_req(1, 1'b1, 8'hFF, 8'h3C, 0, 0, dc);
        do_req(0, 1'b0, 8'hFF, 8'h00, 0, 0, dc);
        check("t4_rdata0", {24'd0, rdata0}, 32'h3C);
        check("t4_rdata1_held", {24'd0, rdata1}, 32'h5A);

        // request withdrawn right after grant still completes
        do_req(0, 1'b1, 8'h20, 8'h77, 1, 0, dc);
        check("t5_done_seen", {31'd0, dc >= 0}, 32'd1);
        do_req(0, 1'b0, 8'h20, 8'h00, 0, 0, dc);
        check("t5_readback", {24'd0, rdata0}, 32'h77);

        // reset lands while port 1's read is in ACCESS
        we[1] = 1'b0; addr[1] = 8'h10; wdata[1] = 8'h00; req[1] = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("t6_gnt_before_reset", {31'd0, gnt1}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t6_strobes_off", {30'd0, mem_we, mem_re}, 32'd0);
        check("t6_no_done", {30'd0, done}, 32'd0);
        check("t6_rdata0_cleared", {24'd0, rdata0}, 32'd0);
        check("t6_no_gnt", {30'd0, gnt}, 32'd0);
        @(posedge clk);
        #1;
        finish_req(1, 0, 0, dc);
        check("t6_regrant_done", {31'd0, dc >= 0}, 32'd1);
        check("t6_rdata1", {24'd0, rdata1}, 32'hA5);

        // randomized traffic from both ports
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    int r, g, d0;
                    g = $urandom_range(0, 3);
                    repeat (g) begin @(posedge clk); #1; end
                    r = $urandom_range(0, 9);
                    do_req(0, 1'($urandom_range(0, 1)),
                           ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom_range(0, 7)),
                           8'($urandom), (r < 6) ? 0 : (r < 8) ? 1 : 2, 0, d0);
                end
            end
            begin
                for (int n = 0; n < 40; n++) begin
                    int r, g, d1;
                    g = $urandom_range(0, 3);
                    repeat (g) begin @(posedge clk); #1; end
                    r = $urandom_range(0, 9);
                    do_req(1, 1'($urandom_range(0, 1)),
                           ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom_range(0, 7)),
                           8'($urandom), (r < 6) ? 0 : (r < 8) ? 1 : 2, 0, d1);
                end
            end
        join

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
